matrix_result_tx: RTL and testbench

Serialises a stored matrix as ASCII decimal text for the UART transmitter. It sits downstream of `matrix_storage` and upstream of `uart_tx`. On `start` it reads elements row-major through a request/valid read port and converts each 8-bit element to decimal digits. It emits bytes over a valid/ready stream, with spaces between columns and CR LF after each row.

---
 rtl/matrix_result_tx_if.sv | 23 ++
 rtl/matrix_result_tx.sv | 161 ++++++++++++++++
 tb/tb_matrix_result_tx.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_result_tx_if.sv
// Element read port and ASCII byte stream of matrix_result_tx.
// master = the serialiser, slave = storage/UART side.
interface matrix_result_tx_if #(
  parameter int ADDR_W = 5
) ();
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [7:0]        rd_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output rd_req, rd_addr, tx_data, tx_valid,
    input  rd_valid, rd_data, tx_ready
  );

  modport slave (
    input  rd_req, rd_addr, tx_data, tx_valid,
    output rd_valid, rd_data, tx_ready
  );
endinterface

// File: rtl/matrix_result_tx.sv
// Prints a stored matrix row-major as ASCII decimal text (space between columns, CR LF per row).
// Define MATRIX_TX_SIGNED_EN to treat elements as two's complement and print a leading '-'.
module matrix_result_tx #(
  parameter int MAX_DIM = 5,
  parameter int ADDR_W  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          dim_m,
  input  logic [2:0]          dim_n,
  matrix_result_tx_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_REQ, S_WAIT, S_CONV, S_EMIT, S_SEP, S_LF, S_DONE
  } state_t;

  localparam logic [3:0] MAX_D = 4'(MAX_DIM);

  state_t     state, state_nx;
  logic [2:0] m_q, n_q, r_q, c_q;
  logic [7:0] data_q;
  logic [7:0] dig_q [4];
  logic [2:0] cnt_q;
  logic [1:0] idx_q;
  logic       err_q;

  logic       hs, dims_bad, last_col, last_row, last_dig;
  logic       neg;
  logic [7:0] mag, hun, ten, uni;
  logic [7:0] cdig [4];
  logic [2:0] ccnt;

  assign hs       = bus.tx_valid && bus.tx_ready;
  assign dims_bad = (m_q == 3'd0) || (n_q == 3'd0) ||
                    ({1'b0, m_q} > MAX_D) || ({1'b0, n_q} > MAX_D);
  assign last_col = (c_q == n_q - 3'd1);
  assign last_row = (r_q + 3'd1 == m_q);
  assign last_dig = ({1'b0, idx_q} + 3'd1 == cnt_q);

  // Digit list is packed from index 0 so EMIT only walks idx up to cnt-1.
  always_comb begin
`ifdef MATRIX_TX_SIGNED_EN
    neg = data_q[7];
    mag = neg ? 8'(~data_q + 8'd1) : data_q;
`else
    neg = 1'b0;
    mag = data_q;
`endif
    hun  = mag / 8'd100;
    ten  = (mag / 8'd10) % 8'd10;
    uni  = mag % 8'd10;
    cdig = '{default: 8'h00};
    ccnt = '0;
    if (neg) begin
      cdig[ccnt[1:0]] = 8'h2D;
      ccnt = ccnt + 3'd1;
    end
    if (hun != 8'd0) begin
      cdig[ccnt[1:0]] = 8'h30 + hun;
      ccnt = ccnt + 3'd1;
    end
    if (hun != 8'd0 || ten != 8'd0) begin
      cdig[ccnt[1:0]] = 8'h30 + ten;
      ccnt = ccnt + 3'd1;
    end
    cdig[ccnt[1:0]] = 8'h30 + uni;
    ccnt = ccnt + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    busy         = (state != S_IDLE) && (state != S_DONE);
    done         = 1'b0;
    err          = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_CHECK;
      S_CHECK: state_nx = dims_bad ? S_DONE : S_REQ;
      S_REQ: begin
        bus.rd_req  = 1'b1;
        bus.rd_addr = ADDR_W'(r_q) * ADDR_W'(n_q) + ADDR_W'(c_q);
        state_nx    = S_WAIT;
      end
      S_WAIT:  if (bus.rd_valid) state_nx = S_CONV;
      S_CONV:  state_nx = S_EMIT;
      S_EMIT: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = dig_q[idx_q];
        if (hs && last_dig) state_nx = S_SEP;
      end
      S_SEP: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = last_col ? 8'h0D : 8'h20;
        if (hs) state_nx = last_col ? S_LF : S_REQ;
      end
      S_LF: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h0A;
        if (hs) state_nx = last_row ? S_DONE : S_REQ;
      end
      S_DONE: begin
        done     = 1'b1;
        err      = err_q;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= '0;
      n_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      data_q <= '0;
      dig_q  <= '{default: 8'h00};
      cnt_q  <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          m_q   <= dim_m;
          n_q   <= dim_n;
          r_q   <= '0;
          c_q   <= '0;
          err_q <= 1'b0;
        end
        S_CHECK: err_q <= dims_bad;
        S_WAIT:  if (bus.rd_valid) data_q <= bus.rd_data;
        S_CONV: begin
          dig_q <= cdig;
          cnt_q <= ccnt;
          idx_q <= '0;
        end
        S_EMIT: if (hs) idx_q <= idx_q + 2'd1;
        S_SEP:  if (hs && !last_col) c_q <= c_q + 3'd1;
        S_LF: if (hs) begin
          c_q <= '0;
          r_q <= r_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_tx.sv
// Directed bench for matrix_result_tx: text model built with $sformatf, checked byte by byte.
module tb_matrix_result_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] dim_m = '0;
  logic [2:0] dim_n = '0;
  logic       busy, done, err;

  matrix_result_tx_if #(.ADDR_W(5)) bus ();

  matrix_result_tx #(.MAX_DIM(5), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .dim_m (dim_m),
    .dim_n (dim_n),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  mem [32];
  byte unsigned exp_q [$];
  int          exp_addr [$];
  string       exp_str, got_str;
  int          rd_delay = 1, rmode = 0, stall = 0;
  bit          stalled = 0;
  int          hs_cnt = 0, tv_cycles = 0, rq_cycles = 0, done_cnt = 0;
  logic        last_err = 1'b0;
  logic        prev_pending = 1'b0, prev_final_lf = 1'b0;
  logic [7:0]  prev_data = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic chk_s(input string name, input string got, input string exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got \"%s\" required \"%s\"", name, got, exp);
    end
  endtask

  // Reference text: each element printed in decimal, ' ' between columns, CR LF per row.
  function automatic void build_model(input int m, input int n);
    string s;
    logic [7:0] v;
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        v = mem[r*n + c];
`ifdef MATRIX_TX_SIGNED_EN
        s = $sformatf("%0d", $signed(v));
`else
        s = $sformatf("%0d", v);
`endif
        s = (c < n - 1) ? {s, " "} : {s, "\r\n"};
        exp_str = {exp_str, s};
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_addr.push_back(r*n + c);
      end
    end
  endfunction

  // Compare process: byte stream, read addresses, hold-under-stall, done timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pending  = 1'b0;
      prev_final_lf = 1'b0;
    end else begin
      if (prev_pending) chk("tx_hold", {bus.tx_valid, bus.tx_data}, {1'b1, prev_data});
      if (prev_final_lf) chk("done_after_lf", done, 1'b1);
      prev_final_lf = 1'b0;
      if (bus.tx_valid) tv_cycles++;
      if (bus.rd_req) begin
        rq_cycles++;
        if (exp_addr.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rd_addr_extra: got rd_req addr %0d, required none", bus.rd_addr);
        end else chk("rd_addr", bus.rd_addr, exp_addr.pop_front());
      end
      if (done) begin
        done_cnt++;
        last_err = err;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        hs_cnt++;
        got_str = $sformatf("%s%c", got_str, bus.tx_data);
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL tx_extra: got byte %0h, required none", bus.tx_data);
        end else begin
          chk("tx_byte", bus.tx_data, exp_q.pop_front());
          prev_final_lf = (exp_q.size() == 0) && (bus.tx_data == 8'h0A);
        end
      end
      prev_pending = bus.tx_valid && !bus.tx_ready;
      prev_data    = bus.tx_data;
    end
  end

  // Memory responder: rd_valid rd_delay cycles after rd_req.
  initial begin
    logic [4:0] a;
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rd_req) begin
        a = bus.rd_addr;
        repeat (rd_delay) @(posedge clk);
        #1 bus.rd_valid = 1'b1; bus.rd_data = mem[a];
        @(posedge clk);
        #1 bus.rd_valid = 1'b0;
      end
    end
  end

  // Consumer: 0 = always ready, 1 = 5-cycle stall on second byte, 2 = random.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1: begin
          if (stall > 0) begin
            bus.tx_ready = 1'b0; stall--;
          end else if (hs_cnt == 1 && !stalled) begin
            bus.tx_ready = 1'b0; stall = 4; stalled = 1;
          end else bus.tx_ready = 1'b1;
        end
        2:       bus.tx_ready = 1'($urandom_range(0, 1));
        default: bus.tx_ready = 1'b1;
      endcase
    end
  end

  task automatic prep(input int m, input int n, input bit model);
    exp_q.delete(); exp_addr.delete();
    exp_str = ""; got_str = "";
    hs_cnt = 0; tv_cycles = 0; rq_cycles = 0; done_cnt = 0; last_err = 1'b0;
    stall = 0; stalled = 0;
    if (model) build_model(m, n);
  endtask

  task automatic run_job(input int m, input int n, input int dly, input int mode,
                         input bit extra_start, input bit exp_err, input string lit);
    rd_delay = dly;
    rmode    = mode;
    prep(m, n, !exp_err);
    @(posedge clk); #1 start = 1'b1; dim_m = 3'(m); dim_n = 3'(n);
    @(posedge clk); #1 start = 1'b0; dim_m = 3'd7; dim_n = 3'd7;
    chk("busy_T1", busy, 1'b1);
    @(posedge clk); #1;
    if (exp_err) begin
      chk("err_T2", {done, err, busy}, 3'b110);
    end else begin
      chk("rdreq_T2", {bus.rd_req, bus.rd_addr}, {1'b1, 5'd0});
      if (dly == 1) begin
        repeat (2) @(posedge clk);
        #1 chk("tx_idle_T4", bus.tx_valid, 1'b0);
        @(posedge clk);
        #1 chk("first_byte_T5", {bus.tx_valid, bus.tx_data}, {1'b1, exp_str.getc(0)});
      end
    end
    if (extra_start) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1; dim_m = 3'd1; dim_n = 3'd1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < 4000 && done_cnt == 0; i++) @(posedge clk);
    repeat (6) @(posedge clk);
    chk("done_count", done_cnt, 1);
    chk("err_flag", last_err, exp_err);
    chk("bytes_left", exp_q.size(), 0);
    chk("addr_left", exp_addr.size(), 0);
    chk_s("text_model", got_str, exp_str);
    if (lit != "") chk_s("text_literal", got_str, lit);
    if (exp_err) chk("no_activity", {tv_cycles[15:0], rq_cycles[15:0]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    string lit_1x3, lit_128;
`ifdef MATRIX_TX_SIGNED_EN
    lit_1x3 = "0 100 -1\r\n";
    lit_128 = "-128\r\n";
`else
    lit_1x3 = "0 100 255\r\n";
    lit_128 = "128\r\n";
`endif
    repeat (2) @(posedge clk);
    #1 chk("reset_state", {bus.rd_req, bus.rd_addr, bus.tx_data, bus.tx_valid, busy, done, err}, '0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    mem[0] = 8'd11; mem[1] = 8'd22; mem[2] = 8'd33; mem[3] = 8'd44;
    run_job(2, 2, 1, 0, 0, 0, "11 22\r\n33 44\r\n");
    chk("hs_count_2x2", hs_cnt, 14);
    run_job(2, 2, 1, 1, 0, 0, "11 22\r\n33 44\r\n");
    run_job(2, 2, 7, 0, 0, 0, "11 22\r\n33 44\r\n");

    mem[0] = 8'd0; mem[1] = 8'd100; mem[2] = 8'd255;
    run_job(1, 3, 1, 0, 0, 0, lit_1x3);
    mem[0] = 8'd128;
    run_job(1, 1, 1, 0, 0, 0, lit_128);

    run_job(0, 3, 1, 0, 0, 1, "");
    run_job(2, 6, 1, 0, 0, 1, "");

    for (int i = 0; i < 9; i++) mem[i] = 8'((i + 1) * 10);
    run_job(3, 3, 1, 0, 1, 0, "10 20 30\r\n40 50 60\r\n70 80 90\r\n");

    for (int i = 0; i < 25; i++) mem[i] = 8'((i * 37 + 5) % 256);
    run_job(5, 5, 2, 2, 0, 0, "");
    run_job(5, 1, 1, 2, 0, 0, "");

    // Reset during the second row, then a fresh full print.
    for (int i = 0; i < 9; i++) mem[i] = 8'((i + 1) * 10);
    rd_delay = 1; rmode = 0;
    prep(3, 3, 1);
    @(posedge clk); #1 start = 1'b1; dim_m = 3'd3; dim_n = 3'd3;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 2000 && hs_cnt < 11; i++) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("mid_reset", {bus.rd_req, bus.rd_addr, bus.tx_data, bus.tx_valid, busy, done, err}, '0);
    chk("abandoned_no_done", done_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    run_job(3, 3, 1, 0, 0, 0, "10 20 30\r\n40 50 60\r\n70 80 90\r\n");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
